// File: rtl/regfile_write_scheduler.sv
// Purpose: merge pipeline writebacks and queued multi-cycle results onto one register-file write port, with a busy scoreboard for decode.
// Latency: a grant in cycle N drives rf_we/rf_waddr/rf_wdata in cycle N+1; an mc result arriving on an empty queue can be granted in the same cycle.
// Backpressure: writebacks are never stalled; mc results are held off through mc_ready when the queue is full; decode is stalled through stall.
module regfile_write_scheduler #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  input  logic [4:0]        mc_reg,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  input  logic              mc_issue,
  input  logic [4:0]        issue_reg,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic              stall,
  output logic [31:0]       busy,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] dat;
  } entry_t;

  entry_t            q_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              q_empty;
  logic              q_full;
  logic              enq;
  logic              deq;
  entry_t            mc_entry;
  entry_t            head;

  logic              grant_vld;
  logic              mc_grant;
  logic [4:0]        grant_reg;
  logic [DATA_W-1:0] grant_dat;
  logic              grant_wr;
  logic [31:0]       busy_nxt;

  assign q_empty  = (count == '0);
  assign q_full   = (count == FULL_CNT);
  // A full queue refuses new results even if its head drains this cycle.
  assign mc_ready = !q_full && rst;
  assign enq      = mc_valid && mc_ready;
  assign mc_entry = '{rd: mc_reg, dat: mc_data};

  // Arbitration: writeback wins; otherwise the queue head (or the incoming mc result when the queue is empty) drains.
  always_comb begin
    grant_vld = 1'b0;
    mc_grant  = 1'b0;
    grant_reg = '0;
    grant_dat = '0;
    deq       = 1'b0;
    head      = q_empty ? mc_entry : q_mem[rd_ptr];
    if (wb_valid) begin
      grant_vld = 1'b1;
      grant_reg = wb_reg;
      grant_dat = wb_data;
    end else if (!q_empty || enq) begin
      grant_vld = 1'b1;
      mc_grant  = 1'b1;
      grant_reg = head.rd;
      grant_dat = head.dat;
      deq       = 1'b1;
    end
  end

  // r0 is hardwired: a grant to it is consumed but never reaches the register file.
  assign grant_wr = grant_vld && (grant_reg != 5'd0);

  // Queue storage; the bypass case writes and reads the same slot, keeping the pointers uniform.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_mem[wr_ptr] <= mc_entry;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard update: clear on an mc grant, then set on issue so a same-register collision stays busy.
  always_comb begin
    busy_nxt = busy;
    if (mc_grant && (grant_reg != 5'd0)) begin
      busy_nxt[grant_reg] = 1'b0;
    end
    if (mc_issue && (issue_reg != 5'd0)) begin
      busy_nxt[issue_reg] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Registered write-port drive; address and data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_wr;
      if (grant_wr) begin
        rf_waddr <= grant_reg;
        rf_wdata <= grant_dat;
      end
    end
  end

  // Decode holds on any busy operand, or when a new mc op would have no queue slot to land in.
  assign stall = busy[id_rs] | busy[id_rt] | busy[id_rd] | (q_full && mc_issue);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              mc_valid;
  logic [4:0]        mc_reg;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;
  logic              mc_issue;
  logic [4:0]        issue_reg;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              stall;
  logic [31:0]       busy;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_ready(mc_ready),
    .mc_issue(mc_issue), .issue_reg(issue_reg),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .stall(stall), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending mc results as a plain FIFO, busy as a bit set, last write.
  typedef struct packed {
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic [31:0]       mbusy;
  logic              mwe;
  logic [4:0]        maddr;
  logic [DATA_W-1:0] mdata;
  bit                addr_known;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b1;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
    mc_issue = 1'b0; issue_reg = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy = '0;
    mwe = 1'b0;
    maddr = '0;
    mdata = '0;
    addr_known = 1'b1;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit          exp_ready;
    bit          exp_stall;
    bit          g;
    bit          from_mc;
    ent_t        e;
    logic [4:0]  gr;
    logic [DATA_W-1:0] gd;
    logic [31:0] nb;
    #1;
    exp_ready = rst && (mq.size() < DEPTH);
    exp_stall = mbusy[id_rs] | mbusy[id_rt] | mbusy[id_rd] | ((mq.size() == DEPTH) && mc_issue);
    chk("mc_ready", {63'd0, mc_ready}, {63'd0, exp_ready});
    chk("stall", {63'd0, stall}, {63'd0, exp_stall});
    if (!rst) begin
      model_reset();
    end else begin
      if (mc_valid && exp_ready) begin
        e = '{r: mc_reg, d: mc_data};
        mq.push_back(e);
      end
      g = 1'b0; from_mc = 1'b0; gr = '0; gd = '0;
      if (wb_valid) begin
        g = 1'b1; gr = wb_reg; gd = wb_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        g = 1'b1; from_mc = 1'b1; gr = e.r; gd = e.d;
      end
      nb = mbusy;
      if (from_mc && gr != 0) nb[gr] = 1'b0;
      if (mc_issue && issue_reg != 0) nb[issue_reg] = 1'b1;
      mbusy = nb;
      mwe = g && (gr != 0);
      if (mwe) begin
        maddr = gr; mdata = gd; addr_known = 1'b1;
      end else if (g) begin
        addr_known = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("rf_we", {63'd0, rf_we}, {63'd0, mwe});
    chk("busy", {32'd0, busy}, {32'd0, mbusy});
    if (addr_known) begin
      chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, maddr});
      chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, mdata});
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
    chk("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    chk("reset_busy", {32'd0, busy}, 64'd0);
    chk("reset_mc_ready", {63'd0, mc_ready}, 64'd0);
    step();
    clear_inputs();

    // Single writeback in cycle 5, visible in cycle 6 only.
    for (int i = 0; i < 3; i++) step();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h11;
    step();
    chk("wb_we", {63'd0, rf_we}, 64'd1);
    chk("wb_addr", {59'd0, rf_waddr}, 64'd3);
    chk("wb_data", {32'd0, rf_wdata}, 64'h11);
    clear_inputs();
    step();
    chk("wb_once", {63'd0, rf_we}, 64'd0);

    // Writeback beats a simultaneous mc result, which follows a cycle later.
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h55;
    mc_valid = 1'b1; mc_reg = 5'd4; mc_data = 32'hAA;
    step();
    chk("conf_first", {59'd0, rf_waddr}, 64'd2);
    clear_inputs();
    step();
    chk("conf_second_we", {63'd0, rf_we}, 64'd1);
    chk("conf_second", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd4, 32'hAA});
    step();

    // Queue fills behind a 4-cycle writeback burst, then drains in order.
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'd20 + 5'(i); wb_data = 32'h100 + i;
      mc_valid = 1'b1;
      mc_reg = (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd10;
      mc_data = 32'hC00 + 32'(mc_reg);
      if (i >= 2) begin
        #1;
        chk("full_ready", {63'd0, mc_ready}, 64'd0);
      end
      step();
    end
    wb_valid = 1'b0;
    step();
    chk("drain_a", {59'd0, rf_waddr}, 64'd8);
    step();
    chk("drain_b", {59'd0, rf_waddr}, 64'd9);
    mc_valid = 1'b0;
    step();
    chk("drain_c", {59'd0, rf_waddr}, 64'd10);
    clear_inputs();
    step();

    // Scoreboard stall on reg 7 until its mc result is granted.
    mc_issue = 1'b1; issue_reg = 5'd7;
    step();
    clear_inputs();
    id_rs = 5'd7;
    #1;
    chk("stall_set", {63'd0, stall}, 64'd1);
    step();
    step();
    mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'h77;
    step();
    chk("busy7_clear", {63'd0, busy[7]}, 64'd0);
    mc_valid = 1'b0;
    #1;
    chk("stall_clear", {63'd0, stall}, 64'd0);
    step();

    // Register 0 is never written and never busy.
    clear_inputs();
    mc_valid = 1'b1; mc_reg = 5'd0; mc_data = 32'hDEAD;
    step();
    chk("r0_we", {63'd0, rf_we}, 64'd0);
    clear_inputs();
    mc_issue = 1'b1; issue_reg = 5'd0;
    step();
    chk("r0_busy", {32'd0, busy}, 64'd0);

    // Reset mid-operation drops queued results and the scoreboard.
    clear_inputs();
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h1;
    mc_valid = 1'b1; mc_reg = 5'd5; mc_data = 32'h5;
    mc_issue = 1'b1; issue_reg = 5'd12;
    step();
    mc_reg = 5'd6; mc_data = 32'h6; mc_issue = 1'b0;
    step();
    clear_inputs();
    rst = 1'b0;
    step();
    clear_inputs();
    #1;
    chk("rst_ready", {63'd0, mc_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_we", {63'd0, rf_we}, 64'd0);
    end
    chk("rst_busy", {32'd0, busy}, 64'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(99) >= 2);
      wb_valid  = ($urandom_range(99) < 40);
      wb_reg    = 5'($urandom_range(7));
      wb_data   = $urandom;
      mc_valid  = ($urandom_range(99) < 55);
      mc_reg    = 5'($urandom_range(7));
      mc_data   = $urandom;
      mc_issue  = ($urandom_range(99) < 30);
      issue_reg = 5'($urandom_range(7));
      id_rs     = 5'($urandom_range(9));
      id_rt     = 5'($urandom_range(9));
      id_rd     = 5'($urandom_range(31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 Parameter DATA_W, default 32: width of the write data in bits.
REQ-002 Parameter DEPTH, default 2: number of entries in the multi-cycle result queue (power of two, at least 2).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port wb_valid / wb_reg / wb_data, input, 1 / 5 / DATA_W bits: pipeline writeback request; it SHALL always be accepted (no backpressure).
REQ-006 Port mc_valid / mc_reg / mc_data, input, 1 / 5 / DATA_W bits: multi-cycle unit result request.
REQ-007 Port mc_ready, output, 1 bit: the queue can accept an mc request this cycle.
REQ-008 Port mc_issue / issue_reg, input, 1 / 5 bits: a multi-cycle operation targeting issue_reg is issued this cycle.
REQ-009 Port id_rs / id_rt / id_rd, input, 5 bits each: register operands of the instruction in decode.
REQ-010 Port stall, output, 1 bit: the decode stage must hold.
REQ-011 Port busy, output, 32 bits: scoreboard of registers with an outstanding multi-cycle result.
REQ-012 Port rf_we / rf_waddr / rf_wdata, output, 1 / 5 / DATA_W bits: registered drive of the register file write port (the register file samples on the falling edge).

Function
REQ-013 mc acceptance: an mc request SHALL be enqueued when mc_valid && mc_ready; mc_ready = (count < DEPTH) && rst.
REQ-014 Write arbitration per cycle: if wb_valid, the wb request SHALL be granted; otherwise, if the queue is non-empty, the queue head SHALL be granted and dequeued.
REQ-015 When wb and the queue head conflict, the head SHALL remain queued and its count SHALL be unchanged.
REQ-016 Latency: a request granted in cycle N SHALL appear on rf_we/rf_waddr/rf_wdata in cycle N+1; with no grant, rf_we SHALL be 0 and rf_waddr/rf_wdata SHALL hold their values.
REQ-017 Empty-queue bypass: an mc request arriving on an empty queue with wb_valid=0 SHALL be enqueued and dequeued in the same cycle, giving rf_we in cycle N+1.
REQ-018 Full queue with wb_valid=0: a simultaneous enqueue and dequeue SHALL keep the count equal to DEPTH, and mc_ready SHALL remain 0 that cycle.
REQ-019 Queue order: entries SHALL leave strictly FIFO; the read and write pointers SHALL wrap modulo DEPTH.
REQ-020 Register 0: any grant with reg=0 SHALL be consumed (queue entry dropped) with rf_we=0; busy[0] SHALL always read 0.
REQ-021 Scoreboard set: mc_issue with issue_reg≠0 SHALL set busy[issue_reg] on the next edge.
REQ-022 Scoreboard clear: busy[r] SHALL clear on the edge at which an mc entry for r is granted.
REQ-023 Simultaneous set and clear of the same register SHALL leave busy[r]=1.
REQ-024 stall = busy[id_rs] | busy[id_rt] | busy[id_rd], combinational, with index 0 contributing 0; stall SHALL also assert when count==DEPTH and mc_issue=1.
REQ-025 Counters: count SHALL be ceil(log2(DEPTH))+1 bits wide and SHALL never exceed DEPTH or underflow.

Reset
REQ-026 With rst=0 at a rising edge: queue empty (count, read pointer and write pointer 0), busy=0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-027 While rst=0: mc_ready=0, and every request SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard queued entries without emitting any write, and the first edge after release SHALL behave as from an empty queue.

Verification
REQ-029 Stimulus: wb_valid=1, wb_reg=3, wb_data=0x11 in cycle 5. Required: rf_we=1, rf_waddr=3, rf_wdata=0x11 in cycle 6 only.
REQ-030 Stimulus: mc_valid (reg 4, 0xAA) and wb_valid (reg 2, 0x55) in the same cycle, then idle. Required: reg 2 is written next cycle, then reg 4 (0xAA) the cycle after.
REQ-031 Stimulus: wb_valid held for 4 cycles while 3 mc requests are offered. Required: mc_ready drops to 0 after 2 are accepted; the 3rd is held off; all 3 write in order once wb goes idle.
REQ-032 Stimulus: mc_issue with issue_reg=7, then id_rs=7. Required: stall=1 until the mc result for reg 7 is granted; busy[7] clears on that edge and stall=0 the next cycle.
REQ-033 Stimulus: mc result for reg 0, and separately mc_issue with issue_reg=0. Required: no rf_we, and busy stays 0.
REQ-034 Stimulus: 2 entries queued, rst=0 for 1 cycle. Required: no rf_we afterwards, busy=0, mc_ready=1 after release.
